// File: rtl/program_loader_if.sv
// Program loader bus: byte load stream in, instruction-memory writes
// and CPU control out.
interface program_loader_if #(
  parameter int ADDR_W = 9
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              restart;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    output in_valid,
    output in_data,
    output restart,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  cpu_hold,
    input  done,
    input  error
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  restart,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output cpu_hold,
    output done,
    output error
  );
endinterface

// File: rtl/program_loader.sv
// Byte-stream program loader: header count, big-endian words,
// checksum byte; holds the CPU in reset until a verified load.
module program_loader #(
  parameter int MEM_WORDS = 128,
  parameter int ADDR_W    = 9
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam logic [16:0] MAXW = 17'(MEM_WORDS);

  state_t            state;
  state_t            state_n;
  logic [15:0]       count;
  logic [15:0]       idx;
  logic [15:0]       idx_inc;
  logic [7:0]        sum;
  logic [7:0]        sum_nx;
  logic [31:0]       asmb;
  logic [1:0]        bcnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [15:0]       cnt_new;
  logic              xfer;
  logic              rdy;
  logic              we;
  logic              hold;
  logic              dn;
  logic              er;

  assign xfer    = bus.in_valid & rdy;
  assign cnt_new = {count[15:8], bus.in_data};
  assign idx_inc = idx + 16'd1;
  assign sum_nx  = sum + bus.in_data;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= HDR_HI;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      HDR_HI: begin
        if (xfer) state_n = HDR_LO;
      end
      HDR_LO: begin
        if (xfer) begin
          if ({1'b0, cnt_new} > MAXW)
            state_n = ERR;
          else if (cnt_new == 16'd0)
            state_n = CHECK;
          else
            state_n = DATA;
        end
      end
      DATA: begin
        if (xfer && bcnt == 2'd3)
          state_n = WRITE;
      end
      WRITE: begin
        if (idx_inc == count)
          state_n = CHECK;
        else
          state_n = DATA;
      end
      CHECK: begin
        if (xfer)
          state_n = (sum_nx == 8'd0) ? DONE : ERR;
      end
      DONE, ERR: begin
        if (bus.restart) state_n = HDR_HI;
      end
      default: state_n = HDR_HI;
    endcase
  end

  // Output decode
  always_comb begin
    rdy  = 1'b0;
    we   = 1'b0;
    hold = 1'b1;
    dn   = 1'b0;
    er   = 1'b0;
    unique case (1'b1)
      (state == HDR_HI),
      (state == HDR_LO),
      (state == DATA),
      (state == CHECK): rdy  = 1'b1;
      (state == WRITE): we   = 1'b1;
      (state == DONE): begin
        hold = 1'b0;
        dn   = 1'b1;
      end
      (state == ERR): er = 1'b1;
      default: ;
    endcase
  end

  // Header, word assembly, checksum and write-port registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= '0;
      idx     <= '0;
      sum     <= '0;
      asmb    <= '0;
      bcnt    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state)
        HDR_HI: begin
          if (xfer) begin
            count[15:8] <= bus.in_data;
            sum         <= sum_nx;
          end
        end
        HDR_LO: begin
          if (xfer) begin
            count[7:0] <= bus.in_data;
            sum        <= sum_nx;
          end
        end
        DATA: begin
          if (xfer) begin
            asmb <= {asmb[23:0], bus.in_data};
            bcnt <= bcnt + 2'd1;
            sum  <= sum_nx;
            if (bcnt == 2'd3) begin
              addr_q  <= ADDR_W'({idx, 2'b00});
              wdata_q <= {asmb[23:0], bus.in_data};
            end
          end
        end
        WRITE: begin
          idx <= idx_inc;
        end
        DONE, ERR: begin
          if (bus.restart) begin
            count <= '0;
            idx   <= '0;
            sum   <= '0;
            asmb  <= '0;
            bcnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_hold  = hold;
  assign bus.done      = dn;
  assign bus.error     = er;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: loads, bad checksum, oversize,
// empty program, back-pressure, mid-load reset and restart.
module tb_program_loader;

  logic clk = 1'b0;
  logic reset;
  bit   bp;
  int   total = 0;
  int   bad   = 0;

  logic [7:0]  strm[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(9)) bus ();

  program_loader #(
    .MEM_WORDS(128),
    .ADDR_W(9)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always @(posedge clk) begin
    if (reset && bus.mem_we === 1'b1) begin
      wa.push_back(32'(bus.mem_addr));
      wd.push_back(bus.mem_wdata);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bit ok;
    bit r;
    int n;
    ok = 0;
    n  = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      bus.in_data  = b;
      bus.in_valid = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      r = bus.in_ready && bus.in_valid;
      @(posedge clk);
      if (r) ok = 1;
      n++;
    end
    #1 bus.in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send(strm[i]);
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
  endtask

  task automatic clr();
    wa.delete();
    wd.delete();
  endtask

  task automatic load_stream(input logic [7:0] cs);
    strm = '{8'h00, 8'h02,
             8'h20, 8'h08, 8'h00, 8'h05,
             8'h20, 8'h09, 8'h00, 8'h07};
    strm.push_back(cs);
  endtask

  task automatic chk_two(input string t);
    chk({t, "_nwr"}, 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk({t, "_a0"}, wa[0], 32'h0);
      chk({t, "_d0"}, wd[0], 32'h20080005);
      chk({t, "_a1"}, wa[1], 32'h4);
      chk({t, "_d1"}, wd[1], 32'h20090007);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    bp           = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.restart  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_we",    32'(bus.mem_we),    32'd0);
    chk("rst_addr",  32'(bus.mem_addr),  32'd0);
    chk("rst_wdata", bus.mem_wdata,      32'd0);
    chk("rst_hold",  32'(bus.cpu_hold),  32'd1);
    chk("rst_done",  32'(bus.done),      32'd0);
    chk("rst_err",   32'(bus.error),     32'd0);
    reset = 1'b1;
    chk("rst_rdy",   32'(bus.in_ready),  32'd1);

    // Good load; sum of bytes 0x5F, checksum 0xA1
    clr();
    load_stream(8'hA1);
    send_range(0, 5);
    @(negedge clk);
    chk("lat_we",   32'(bus.mem_we),   32'd1);
    chk("lat_addr", 32'(bus.mem_addr), 32'd0);
    chk("lat_data", bus.mem_wdata,     32'h20080005);
    chk("lat_rdy",  32'(bus.in_ready), 32'd0);
    send_range(6, 9);
    chk("pre_done", 32'(bus.done),     32'd0);
    send(strm[10]);
    chk("ld_done",  32'(bus.done),     32'd1);
    chk("ld_hold",  32'(bus.cpu_hold), 32'd0);
    @(negedge clk);
    chk("ld_we0",   32'(bus.mem_we),   32'd0);
    chk("ld_addr",  32'(bus.mem_addr), 32'd4);
    chk_two("ld");

    // Restart, then one word DEADBEEF (checksum 0xC7); restart mid-load ignored
    pulse_restart();
    chk("rs_hold", 32'(bus.cpu_hold), 32'd1);
    chk("rs_done", 32'(bus.done),     32'd0);
    chk("rs_rdy",  32'(bus.in_ready), 32'd1);
    clr();
    strm = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC7};
    send_range(0, 2);
    pulse_restart();
    send_range(3, 6);
    chk("ow_done", 32'(bus.done), 32'd1);
    chk("ow_nwr",  32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("ow_addr", wa[0], 32'h0);
      chk("ow_data", wd[0], 32'hDEADBEEF);
    end

    // Bad checksum
    pulse_restart();
    clr();
    load_stream(8'hA2);
    send_range(0, 10);
    @(negedge clk);
    chk("bc_err",  32'(bus.error),    32'd1);
    chk("bc_done", 32'(bus.done),     32'd0);
    chk("bc_hold", 32'(bus.cpu_hold), 32'd1);
    chk("bc_rdy",  32'(bus.in_ready), 32'd0);
    chk_two("bc");

    // Oversize count 0x0081
    pulse_restart();
    chk("rs2_err", 32'(bus.error), 32'd0);
    clr();
    send(8'h00);
    send(8'h81);
    chk("ov_err", 32'(bus.error),    32'd1);
    chk("ov_rdy", 32'(bus.in_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("ov_nwr", 32'(wa.size()),    32'd0);

    // Empty program, good and bad checksum
    pulse_restart();
    clr();
    send(8'h00);
    send(8'h00);
    send(8'h00);
    chk("em_done", 32'(bus.done),  32'd1);
    chk("em_nwr",  32'(wa.size()), 32'd0);
    pulse_restart();
    send(8'h00);
    send(8'h00);
    send(8'h05);
    chk("em_err",  32'(bus.error), 32'd1);
    chk("em_nwr2", 32'(wa.size()), 32'd0);

    // Back-pressure
    pulse_restart();
    clr();
    bp = 1'b1;
    load_stream(8'hA1);
    send_range(0, 10);
    bp = 1'b0;
    chk("bp_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    chk_two("bp");

    // Reset after 5 data bytes, then full load
    pulse_restart();
    send_range(0, 6);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mr_hold", 32'(bus.cpu_hold), 32'd1);
    chk("mr_rdy",  32'(bus.in_ready), 32'd1);
    clr();
    send_range(0, 10);
    chk("mr_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    chk_two("mr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
